// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM request ports and shared pmem port bundle
//
// Purpose: groups the two datapath-side memory ports and the shared
// physical-memory port into one bundle.
//   master : environment view (datapath requesters + pmem model)
//   slave  : arbiter view
// Signals:
//   instr_mem_read/address -> req, instr_mem_rdata/resp <- resp
//   data_mem_read/write/mbe/address/wdata -> req, data_mem_rdata/resp <- resp
//   pmem_read/write/mbe/address/wdata <- arbiter, pmem_rdata/resp -> arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MBE_W = DATA_W / 8;

  logic              instr_mem_read;
  logic [ADDR_W-1:0] instr_mem_address;
  logic [DATA_W-1:0] instr_mem_rdata;
  logic              instr_mem_resp;

  logic              data_mem_read;
  logic              data_mem_write;
  logic [MBE_W-1:0]  data_mem_mbe;
  logic [ADDR_W-1:0] data_mem_address;
  logic [DATA_W-1:0] data_mem_wdata;
  logic [DATA_W-1:0] data_mem_rdata;
  logic              data_mem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [MBE_W-1:0]  pmem_mbe;
  logic [ADDR_W-1:0] pmem_address;
  logic [DATA_W-1:0] pmem_wdata;
  logic [DATA_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output instr_mem_read, instr_mem_address,
    input  instr_mem_rdata, instr_mem_resp,
    output data_mem_read, data_mem_write, data_mem_mbe, data_mem_address, data_mem_wdata,
    input  data_mem_rdata, data_mem_resp,
    input  pmem_read, pmem_write, pmem_mbe, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  instr_mem_read, instr_mem_address,
    output instr_mem_rdata, instr_mem_resp,
    input  data_mem_read, data_mem_write, data_mem_mbe, data_mem_address, data_mem_wdata,
    output data_mem_rdata, data_mem_resp,
    output pmem_read, pmem_write, pmem_mbe, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF and MEM memory ports onto one pmem port
//
// Purpose: accepts requests from the instruction-fetch and data ports, runs
// one transaction at a time on the shared pmem port and returns a one-cycle
// resp pulse with read data to the port that asked. Contention alternates.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous reset, active-high
//   bus  : mem_port_arbiter_if.slave (request ports + shared pmem port)
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);
  localparam int MBE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } state_e;

  state_e            state_q,     state_d;
  logic              last_d_q,    last_d_d;   // 1: most recent grant went to D
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [MBE_W-1:0]  mbe_q,       mbe_d;
  logic              write_q,     write_d;
  logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

  logic i_req;
  logic d_req;
  logic serving;

  assign i_req = bus.instr_mem_read;
  assign d_req = bus.data_mem_read | bus.data_mem_write;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mbe_d     = mbe_q;
    write_d   = write_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        // D wins a tie unless it also won the previous grant.
        if (d_req && (!i_req || !last_d_q)) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = bus.data_mem_address & ~ADDR_W'(3);
          wdata_d  = bus.data_mem_wdata;
          // read+write together is a write
          write_d  = bus.data_mem_write;
          mbe_d    = bus.data_mem_write ? bus.data_mem_mbe : '1;
        end else if (i_req) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = bus.instr_mem_address & ~ADDR_W'(3);
          wdata_d  = '0;
          write_d  = 1'b0;
          mbe_d    = '1;
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          i_rdata_d = bus.pmem_rdata;
          state_d   = RESP_I;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          if (!write_q) begin
            d_rdata_d = bus.pmem_rdata;
          end
          state_d = RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mbe_q     <= '0;
      write_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mbe_q     <= mbe_d;
      write_q   <= write_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // pmem side is driven purely from state and request registers, so it
  // cannot glitch with requester inputs and is quiet outside SERVE_x.
  assign serving          = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign bus.pmem_read    = serving & ~write_q;
  assign bus.pmem_write   = serving &  write_q;
  assign bus.pmem_mbe     = serving ? mbe_q   : '0;
  assign bus.pmem_address = serving ? addr_q  : '0;
  assign bus.pmem_wdata   = serving ? wdata_q : '0;

  assign bus.instr_mem_resp  = (state_q == RESP_I);
  assign bus.instr_mem_rdata = i_rdata_q;
  assign bus.data_mem_resp   = (state_q == RESP_D);
  assign bus.data_mem_rdata  = d_rdata_q;
endmodule
